spart_q: RTL

- Parametrised successor to the current serial port: memory-mapped UART with independently sized TX/RX FIFOs, programmable parity and stop bits, sticky error flags, RX watermark and interrupt output.
- Sits on the processor I/O bus behind a chip-select decode.
- Self-contained: TX/RX shift engines and both FIFOs are inside the block.

---
 rtl/spart_q.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spart_q.sv
// spart_q: memory-mapped UART with TX/RX FIFOs, parity/stop control, sticky errors and RX watermark irq.
// Latency: a byte written at addr 0 reaches the line (start bit) one clock later when TX is idle; irq is one clock behind its cause.
// Backpressure: writes to a full TX FIFO and RX frames arriving at a full RX FIFO are dropped (the latter sets overrun).

module spart_q_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             push_dat,
  input  logic                   pop,
  output logic [7:0]             head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  // A push while full is ignored even if a pop happens in the same cycle.
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  // Storage; entries are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally (power-of-2 depth); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module spart_q #(
  parameter int               TX_DEPTH = 8,
  parameter int               RX_DEPTH = 8,
  parameter int               DIV_W    = 13,
  parameter logic [DIV_W-1:0] DIV_RST  = DIV_W'(434)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs_n,
  input  logic       iorw_n,
  input  logic [2:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       tx_q_full,
  output logic       rx_q_empty,
  output logic       irq,
  output logic       TX,
  input  logic       RX
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  logic             wr, rd;
  logic [DIV_W-1:0] div_q, eff_div, eff_m1, half_m1;
  logic [5:0]       ctrl_q;
  logic [7:0]       wm_q;
  logic [7:0]       rd_dat;
  logic             par_en, par_odd, stop2, rx_ie, tx_ie, loopback;

  logic             tx_full, tx_empty, tx_pop, tx_done, tx_last_stop;
  logic [7:0]       tx_head;
  logic [TAW:0]     tx_count;
  tx_state_t        tx_st;
  logic [DIV_W-1:0] tx_cnt;
  logic [7:0]       tx_sh;
  logic [2:0]       tx_bit;
  logic             tx_pbit, tx_line;

  logic             rx_full, rx_empty, rx_push;
  logic [7:0]       rx_head;
  logic [RAW:0]     rx_count;
  rx_state_t        rx_st;
  logic [DIV_W-1:0] rx_cnt;
  logic [7:0]       rx_sh;
  logic [2:0]       rx_bit;
  logic             rx_pbad, rx_s1, rx_s2, rx_prev;

  logic             ovr_q, par_err_q, frm_err_q, irq_q;
  logic [2:0]       clr;

  assign wr = ~iocs_n & ~iorw_n;
  assign rd = ~iocs_n &  iorw_n;

  assign par_en   = (ctrl_q[1:0] == 2'b01) | (ctrl_q[1:0] == 2'b10);
  assign par_odd  = (ctrl_q[1:0] == 2'b10);
  assign stop2    = ctrl_q[2];
  assign rx_ie    = ctrl_q[3];
  assign tx_ie    = ctrl_q[4];
  assign loopback = ctrl_q[5];

  // Divisors below 16 would leave too few clocks per bit for mid-bit sampling.
  assign eff_div = (div_q < DIV_W'(16)) ? DIV_W'(16) : div_q;
  assign eff_m1  = eff_div - DIV_W'(1);
  assign half_m1 = (eff_div >> 1) - DIV_W'(1);

  // Programmable registers: divisor, control, watermark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= DIV_RST;
      ctrl_q <= '0;
      wm_q   <= '0;
    end else if (wr) begin
      case (ioaddr)
        3'd2:    div_q[7:0]       <= databus;
        3'd3:    div_q[DIV_W-1:8] <= databus[DIV_W-9:0];
        3'd4:    ctrl_q           <= databus[5:0];
        3'd7:    wm_q             <= databus;
        default: ;
      endcase
    end
  end

  spart_q_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(wr & (ioaddr == 3'd0)), .push_dat(databus),
    .pop(tx_pop), .head_dat(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  spart_q_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rx_push), .push_dat(rx_sh),
    .pop(rd & (ioaddr == 3'd0)), .head_dat(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // The next frame is loaded either from idle or straight out of the last stop bit (no idle gap).
  assign tx_last_stop = (tx_cnt == '0) &
                        (((tx_st == TX_STOP1) & ~stop2) | (tx_st == TX_STOP2));
  assign tx_pop  = ~tx_empty & ((tx_st == TX_IDLE) | tx_last_stop);
  assign tx_done = (tx_st == TX_IDLE) & tx_empty;
  assign TX      = tx_line;

  // TX engine: each state holds the line for exactly one bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st   <= TX_IDLE;
      tx_cnt  <= '0;
      tx_sh   <= '0;
      tx_bit  <= '0;
      tx_pbit <= 1'b0;
      tx_line <= 1'b1;
    end else if (tx_pop) begin
      tx_st   <= TX_START;
      tx_cnt  <= eff_m1;
      tx_sh   <= tx_head;
      tx_pbit <= (^tx_head) ^ par_odd;
      tx_bit  <= '0;
      tx_line <= 1'b0;
    end else if (tx_st == TX_IDLE) begin
      tx_line <= 1'b1;
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - DIV_W'(1);
    end else begin
      tx_cnt <= eff_m1;
      case (tx_st)
        TX_START: begin
          tx_st   <= TX_DATA;
          tx_line <= tx_sh[0];
          tx_sh   <= {1'b0, tx_sh[7:1]};
        end
        TX_DATA: begin
          if (tx_bit == 3'd7) begin
            tx_st   <= par_en ? TX_PARITY : TX_STOP1;
            tx_line <= par_en ? tx_pbit : 1'b1;
          end else begin
            tx_bit  <= tx_bit + 3'd1;
            tx_line <= tx_sh[0];
            tx_sh   <= {1'b0, tx_sh[7:1]};
          end
        end
        TX_PARITY: begin
          tx_st   <= TX_STOP1;
          tx_line <= 1'b1;
        end
        TX_STOP1: begin
          tx_st   <= stop2 ? TX_STOP2 : TX_IDLE;
          tx_line <= 1'b1;
        end
        default: begin
          tx_st   <= TX_IDLE;
          tx_line <= 1'b1;
        end
      endcase
    end
  end

  // Line synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= loopback ? tx_line : RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_push = (rx_st == RX_STOP) & (rx_cnt == '0);

  // RX engine: half-bit delay after the start edge, then one sample per bit period at mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_sh   <= '0;
      rx_bit  <= '0;
      rx_pbad <= 1'b0;
    end else if (rx_st == RX_IDLE) begin
      if (rx_prev & ~rx_s2) begin
        rx_st  <= RX_START;
        rx_cnt <= half_m1;
      end
    end else if (rx_cnt != '0) begin
      rx_cnt <= rx_cnt - DIV_W'(1);
    end else begin
      rx_cnt <= eff_m1;
      case (rx_st)
        RX_START: begin
          rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
          rx_bit  <= '0;
          rx_pbad <= 1'b0;
        end
        RX_DATA: begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= par_en ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: begin
          rx_pbad <= rx_s2 ^ (^rx_sh) ^ par_odd;
          rx_st   <= RX_STOP;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  assign clr = (wr & (ioaddr == 3'd1)) ? databus[3:1] : 3'b000;

  // Sticky error flags (hardware set beats software clear) and the registered interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q     <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ovr_q     <= (rx_push & rx_full) | (ovr_q     & ~clr[2]);
      par_err_q <= (rx_push & rx_pbad) | (par_err_q & ~clr[1]);
      frm_err_q <= (rx_push & ~rx_s2)  | (frm_err_q & ~clr[0]);
      irq_q     <= (rx_ie & (((wm_q != 8'd0) & (8'(rx_count) >= wm_q)) |
                             ovr_q | par_err_q | frm_err_q)) |
                   (tx_ie & tx_done);
    end
  end

  // Read mux; the bus is only driven while a read is selected.
  always_comb begin
    rd_dat = 8'h00;
    case (ioaddr)
      3'd0: rd_dat = rx_empty ? 8'h00 : rx_head;
      3'd1: rd_dat = {tx_full, tx_done, rx_full, rx_empty, ovr_q, par_err_q, frm_err_q, irq_q};
      3'd2: rd_dat = div_q[7:0];
      3'd3: rd_dat = 8'(div_q[DIV_W-1:8]);
      3'd4: rd_dat = {2'b00, ctrl_q};
      3'd5: rd_dat = 8'(tx_count);
      3'd6: rd_dat = 8'(rx_count);
      default: rd_dat = wm_q;
    endcase
  end

  assign databus    = rd ? rd_dat : 8'bz;
  assign tx_q_full  = tx_full;
  assign rx_q_empty = rx_empty;
  assign irq        = irq_q;
endmodule
